// File: rtl/write_resp_channel_rr_arb.sv
// Round-robin AXI write-response (B) arbiter: N slaves -> registered response routed by BID to M masters.
// Optional back-pressure stall counter enabled by defining WRESP_ARB_STALL_CNT_EN.
module write_resp_channel_rr_arb #(
  parameter int Num_Of_Masters  = 2,
  parameter int Num_Of_Slaves   = 2,
  parameter int Masters_Id_Size = $clog2(Num_Of_Masters),
  parameter int Slaves_Id_Size  = $clog2(Num_Of_Slaves)
) (
  input  logic                                     clk,
  input  logic                                     rst,
  input  logic                                     Channel_Granted,
  input  logic [Num_Of_Slaves*Masters_Id_Size-1:0] S_AXI_BID,
  input  logic [Num_Of_Slaves*2-1:0]               S_AXI_BRESP,
  input  logic [Num_Of_Slaves-1:0]                 S_AXI_BVALID,
  output logic [Num_Of_Slaves-1:0]                 S_AXI_BREADY,
  output logic [Masters_Id_Size-1:0]               M_AXI_BID,
  output logic [1:0]                               M_AXI_BRESP,
  output logic [Num_Of_Masters-1:0]                M_AXI_BVALID,
  input  logic [Num_Of_Masters-1:0]                M_AXI_BREADY,
  output logic                                     Channel_Request,
  output logic [Slaves_Id_Size-1:0]                Selected_Slave,
  output logic [15:0]                              Stall_Count
);

  typedef enum logic {IDLE, HOLD} state_t;

  state_t                      state_q;
  logic [Slaves_Id_Size-1:0]   rr_ptr_q;
  logic [Slaves_Id_Size-1:0]   sel_q;
  logic [Masters_Id_Size-1:0]  bid_q;
  logic [1:0]                  resp_q;
  logic [Num_Of_Masters-1:0]   bvalid_q;

  logic [Slaves_Id_Size-1:0]   winner_d;
  logic [Slaves_Id_Size-1:0]   rr_ptr_d;
  logic [Masters_Id_Size-1:0]  win_bid_d;
  logic [1:0]                  win_resp_d;
  logic [Num_Of_Masters-1:0]   bvalid_d;
  logic [Num_Of_Masters-1:0]   hs_vec;
  logic                        found;
  logic                        any_valid;
  logic                        bid_ok;
  logic                        hs;
  logic                        cap;
  int                          idx;

  // First valid slave at or after rr_ptr_q, wrapping around.
  always_comb begin
    winner_d = rr_ptr_q;
    found    = 1'b0;
    idx      = 0;
    for (int i = 0; i < Num_Of_Slaves; i++) begin
      idx = (int'(rr_ptr_q) + i) % Num_Of_Slaves;
      if (!found && S_AXI_BVALID[idx]) begin
        winner_d = Slaves_Id_Size'(idx);
        found    = 1'b1;
      end
    end
  end

  assign win_bid_d  = S_AXI_BID[winner_d*Masters_Id_Size +: Masters_Id_Size];
  assign win_resp_d = S_AXI_BRESP[winner_d*2 +: 2];
  assign rr_ptr_d   = (int'(winner_d) == Num_Of_Slaves - 1) ? '0 : winner_d + 1'b1;
  assign any_valid  = |S_AXI_BVALID;
  assign bid_ok     = int'(bid_q) < Num_Of_Masters;

  genvar gi;
  generate
    for (gi = 0; gi < Num_Of_Masters; gi++) begin : g_master
      assign hs_vec[gi]   = bvalid_q[gi] & M_AXI_BREADY[gi];
      assign bvalid_d[gi] = (int'(win_bid_d) == gi);
    end
    for (gi = 0; gi < Num_Of_Slaves; gi++) begin : g_slave
      assign S_AXI_BREADY[gi] = cap && (int'(winner_d) == gi);
    end
  endgenerate

  // bvalid_q is only ever set for an in-range BID while holding, so this is the addressed handshake.
  assign hs  = |hs_vec;
  assign cap = !rst && Channel_Granted && any_valid && (state_q == IDLE || hs);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      rr_ptr_q <= '0;
      sel_q    <= '0;
      bid_q    <= '0;
      resp_q   <= '0;
      bvalid_q <= '0;
    end else if (cap) begin
      state_q  <= HOLD;
      rr_ptr_q <= rr_ptr_d;
      sel_q    <= winner_d;
      bid_q    <= win_bid_d;
      resp_q   <= win_resp_d;
      bvalid_q <= bvalid_d;
    end else if (state_q == HOLD && (hs || !bid_ok)) begin
      // Completed, or an out-of-range BID that no master can accept: retire it.
      state_q  <= IDLE;
      bvalid_q <= '0;
    end
  end

`ifdef WRESP_ARB_STALL_CNT_EN
  logic [15:0] stall_q;
  logic        stalled;

  assign stalled = (state_q == HOLD) && bid_ok && !hs;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_q <= '0;
    end else if (hs) begin
      stall_q <= '0;
    end else if (stalled && stall_q != 16'hFFFF) begin
      stall_q <= stall_q + 16'd1;
    end
  end

  assign Stall_Count = stall_q;
`else
  assign Stall_Count = '0;
`endif

  assign M_AXI_BID       = bid_q;
  assign M_AXI_BRESP     = resp_q;
  assign M_AXI_BVALID    = bvalid_q;
  assign Selected_Slave  = sel_q;
  assign Channel_Request = any_valid;

endmodule
